// File: rtl/mips_avalon_ram.sv
// Avalon-MM slave word RAM with programmable waitrequest latency and a sticky bus error flag.
// Optional macro MIPS_AVALON_RAM_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per transfer.
module mips_avalon_ram #(
   parameter int          MEM_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
   parameter int          WAIT_CYCLES   = 2,
   parameter string       RAM_INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        bus_error
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t      state;
   state_t      state_next;
   logic        enter_ack;
   logic [7:0]  cnt;
   logic [7:0]  wait_total;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_be;
   logic        lat_write;
   logic        lat_both;
   logic        req;
   logic        cur_write;
   logic        cur_both;
   logic [31:0] cur_addr;
   logic [31:0] offset;
   logic        in_range;
   logic [AW-1:0] word_idx;
   logic [31:0] mem [MEM_WORDS];

   assign req         = read | write;
   assign waitrequest = req && (state != ACK);

   // In IDLE the live bus is decoded so a zero-wait transfer can complete straight away;
   // afterwards only the latched request matters.
   assign cur_addr  = (state == IDLE) ? address : lat_addr;
   assign cur_write = (state == IDLE) ? write : lat_write;
   assign cur_both  = (state == IDLE) ? (read && write) : lat_both;

   // BASE_ADDR is word aligned, so offset[1:0] equals address[1:0].
   assign offset   = cur_addr - BASE_ADDR;
   assign in_range = (offset[31:2] < 30'(MEM_WORDS)) && (offset[1:0] == 2'b00);
   assign word_idx = offset[AW+1:2];

`ifdef MIPS_AVALON_RAM_RANDOM_WAIT_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else if (state == ACK) begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign wait_total = 8'(WAIT_CYCLES) + {6'b0, lfsr[1:0]};
`else
   assign wait_total = 8'(WAIT_CYCLES);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      enter_ack  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (wait_total == 8'd0) begin
                  state_next = ACK;
                  enter_ack  = 1'b1;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (!req) begin
               state_next = IDLE;
            end else if (cnt == 8'd0) begin
               state_next = ACK;
               enter_ack  = 1'b1;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 8'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_be    <= 4'd0;
         lat_write <= 1'b0;
         lat_both  <= 1'b0;
         readdata  <= 32'd0;
         bus_error <= 1'b0;
      end else begin
         if (state == IDLE && req) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_write <= write;
            lat_both  <= read && write;
            cnt       <= (wait_total == 8'd0) ? 8'd0 : wait_total - 8'd1;
         end
         if (state == BUSY) begin
            if (!req) begin
               bus_error <= 1'b1;
            end else if (cnt != 8'd0) begin
               cnt <= cnt - 8'd1;
            end
         end
         // Write wins over read, so readdata only moves for pure reads.
         if (enter_ack) begin
            if (!in_range || cur_both) begin
               bus_error <= 1'b1;
            end
            if (!cur_write) begin
               readdata <= in_range ? mem[word_idx] : 32'h0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && state == ACK && lat_write && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) begin
               mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
